qs_fifo_occ: RTL and testbench
==============================

Name: qs_fifo_occ

Overview:
Second-generation synchronous FIFO for single-clock datapaths. Supports arbitrary (non-power-of-two) depth, an occupancy count, and almost-full/almost-empty thresholds. Read mode is selectable: registered or first-word-fall-through (FWFT). Sticky overflow/underflow error flags can be cleared by software-side logic. Drop-in successor wherever a plain push/pop FIFO with full/empty is used today.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 4, number of entries; any integer >=2, power of two not required
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through
AF_THRESH, DEPTH-1, almost_full_o asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty_o asserts when count <= AE_THRESH (0..DEPTH-1)
(local) CNT_W = $clog2(DEPTH+1); PTR_W = max(1, $clog2(DEPTH))

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
push_i  input  1  push request
push_data_i  input  DATA_W  write data, sampled when push accepted
pop_i  input  1  pop request
pop_data_o  output  DATA_W  read data
pop_valid_o  output  1  pop_data_o holds a valid word
full_o  output  1  count == DEPTH
empty_o  output  1  count == 0
almost_full_o  output  1  count >= AF_THRESH
almost_empty_o  output  1  count <= AE_THRESH
count_o  output  CNT_W  current occupancy, 0..DEPTH
overflow_o  output  1  sticky: push attempted while full
underflow_o  output  1  sticky: pop attempted while empty
err_clr_i  input  1  clears overflow_o/underflow_o

Behaviour:
- Reset (reset_n low, async assert, sync-to-clk deassert by upstream): rd/wr ptr = 0, count_o = 0, empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0, overflow_o = underflow_o = 0, pop_valid_o = 0, pop_data_o = 0. Storage array not reset. Reset mid-operation discards all contents; first post-reset push lands at entry 0.
- push accepted = push_i & !full_o; pop accepted = pop_i & !empty_o. Flags are the registered state; there is no write-through when full and no read-through when empty.
- Accepted push: mem[wr_ptr] <= push_data_i. wr_ptr increments, wrapping DEPTH-1 -> 0. Accepted pop: rd_ptr likewise.
- count: +1 push only, -1 pop only, unchanged for both or neither. full/empty/almost flags decode from count, registered/glitch-free, valid the cycle after the update.
- Simultaneous push+pop: both accepted when 0 < count < DEPTH. When empty, only the push is accepted and underflow sets. When full, only the pop is accepted and overflow sets.
- FWFT=0: on accepted pop, pop_data_o <= mem[rd_ptr] and pop_valid_o = 1 the next cycle, else pop_valid_o = 0. pop_data_o holds its last value when not popping.
- FWFT=1: pop_valid_o = !empty_o, pop_data_o = mem[rd_ptr] combinationally when non-empty, 0 when empty. Pop acknowledges the current head. A word pushed into an empty FIFO appears one cycle after the push edge.
- overflow_o set on push_i & full_o; underflow_o set on pop_i & empty_o. Both clear on err_clr_i. A set in the same cycle as a clear wins.
- Pointer compare never relies on power-of-two wrap; count is the only full/empty source.

Test Plan:
- DEPTH=5, DATA_W=8, FWFT=0: push 0x11..0x15 on 5 cycles -> full_o=1, count_o=5, almost_full_o from count 4. Sixth push 0x16 -> overflow_o=1, data dropped. Pop 5 -> 0x11..0x15 each one cycle after pop with pop_valid_o=1, then empty_o=1.
- Wrap: DEPTH=5, 3 push / 3 pop repeated 4 rounds (12 words, ptrs wrap twice) -> output order exactly 0x00..0x0B, count_o never > 3.
- Simultaneous: count=2, push+pop for 10 cycles -> count_o stays 2, FIFO order preserved. On empty, push 0xAA + pop -> count_o=1, underflow_o=1, 0xAA is the next popped word.
- FWFT=1, DEPTH=4: push 0x5A into empty -> next cycle pop_valid_o=1, pop_data_o=0x5A with no pop. Pop -> empty_o=1, pop_data_o=0.
- Error clear: set overflow, assert err_clr_i alone -> overflow_o=0 next cycle. err_clr_i with push while full -> overflow_o stays 1.
- Reset mid-stream: count=3, drop reset_n asynchronously between edges -> all outputs at reset values immediately. After release, push 0x77 then pop -> 0x77, no stale data.

Source files
------------

// File: rtl/qs_fifo_occ.sv
// Single-clock FIFO of arbitrary depth with occupancy count, almost-full/almost-empty
// thresholds, sticky error flags, and a selectable registered or FWFT read port.
module qs_fifo_occ #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             push_i,
  input  logic [DATA_W-1:0]                push_data_i,
  input  logic                             pop_i,
  output logic [DATA_W-1:0]                pop_data_o,
  output logic                             pop_valid_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic                             almost_full_o,
  output logic                             almost_empty_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o,
  output logic                             overflow_o,
  output logic                             underflow_o,
  input  logic                             err_clr_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic              push_acc, pop_acc;

  assign push_acc = push_i & ~full_q;
  assign pop_acc  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (push_acc && !pop_acc)
      count_d = count_q + CNT_W'(1);
    else if (pop_acc && !push_acc)
      count_d = count_q - CNT_W'(1);
  end

  // Flags are registered from the next count so they line up with count_o.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (push_acc)
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_acc)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
      af_q    <= (count_d >= CNT_W'(AF_THRESH));
      ae_q    <= (count_d <= CNT_W'(AE_THRESH));
      ovf_q   <= (push_i & full_q) | (ovf_q & ~err_clr_i);
      udf_q   <= (pop_i & empty_q) | (udf_q & ~err_clr_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wr_ptr] <= push_data_i;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_W-1:0] data_q;
      logic              valid_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= pop_acc;
          if (pop_acc)
            data_q <= mem[rd_ptr];
        end
      end

      assign pop_data_o  = data_q;
      assign pop_valid_o = valid_q;
    end else begin : g_fwft_read
      assign pop_valid_o = ~empty_q;
      assign pop_data_o  = empty_q ? '0 : mem[rd_ptr];
    end
  endgenerate

  assign count_o        = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_qs_fifo_occ.sv
// Directed bench: registered-read DEPTH=5 instance and FWFT DEPTH=4 instance.
module tb_qs_fifo_occ;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: DEPTH=5, FWFT=0
  logic       push0 = 1'b0, pop0 = 1'b0, clr0 = 1'b0;
  logic [7:0] din0 = '0, pd0;
  logic       pv0, full0, empty0, af0, ae0, ovf0, udf0;
  logic [2:0] cnt0;

  // Instance 1: DEPTH=4, FWFT=1
  logic       push1 = 1'b0, pop1 = 1'b0, clr1 = 1'b0;
  logic [7:0] din1 = '0, pd1;
  logic       pv1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [2:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  qs_fifo_occ #(.DATA_W(8), .DEPTH(5), .FWFT(0)) u0 (
    .clk(clk), .reset_n(reset_n),
    .push_i(push0), .push_data_i(din0), .pop_i(pop0),
    .pop_data_o(pd0), .pop_valid_o(pv0), .full_o(full0), .empty_o(empty0),
    .almost_full_o(af0), .almost_empty_o(ae0), .count_o(cnt0),
    .overflow_o(ovf0), .underflow_o(udf0), .err_clr_i(clr0)
  );

  qs_fifo_occ #(.DATA_W(8), .DEPTH(4), .FWFT(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .push_i(push1), .push_data_i(din1), .pop_i(pop1),
    .pop_data_o(pd1), .pop_valid_o(pv1), .full_o(full1), .empty_o(empty1),
    .almost_full_o(af1), .almost_empty_o(ae1), .count_o(cnt1),
    .overflow_o(ovf1), .underflow_o(udf1), .err_clr_i(clr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    cyc; cyc;
    chk("rst_cnt0", cnt0, 0);  chk("rst_empty0", empty0, 1);
    chk("rst_ae0", ae0, 1);    chk("rst_full0", full0, 0);
    chk("rst_af0", af0, 0);    chk("rst_ovf0", ovf0, 0);
    chk("rst_udf0", udf0, 0);  chk("rst_pv0", pv0, 0);
    chk("rst_pd0", pd0, 0);
    chk("rst_pv1", pv1, 0);    chk("rst_pd1", pd1, 0);
    chk("rst_empty1", empty1, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- fill to full, overflow ----------------
    for (int i = 0; i < 5; i++) begin
      push0 = 1'b1; din0 = 8'(8'h11 + i);
      cyc;
      chk("fill_cnt", cnt0, i + 1);
      chk("fill_af", af0, (i + 1 >= 4) ? 1 : 0);
      chk("fill_ae", ae0, (i + 1 <= 1) ? 1 : 0);
      chk("fill_full", full0, (i + 1 == 5) ? 1 : 0);
      chk("fill_empty", empty0, 0);
    end
    din0 = 8'h16;
    cyc;
    push0 = 1'b0;
    chk("ovf_set", ovf0, 1);
    chk("ovf_cnt", cnt0, 5);

    // ---------------- drain ----------------
    pop0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc;
      chk("drain_data", pd0, 8'h11 + i);
      chk("drain_valid", pv0, 1);
      chk("drain_cnt", cnt0, 4 - i);
    end
    pop0 = 1'b0;
    cyc;
    chk("drain_idle_valid", pv0, 0);
    chk("drain_empty", empty0, 1);
    chk("drain_hold", pd0, 8'h15);
    chk("drain_no_udf", udf0, 0);

    clr0 = 1'b1;
    cyc;
    clr0 = 1'b0;
    chk("ovf_clr", ovf0, 0);

    // ---------------- pointer wrap ----------------
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        push0 = 1'b1; din0 = 8'(r * 3 + k);
        cyc;
      end
      push0 = 1'b0;
      chk("wrap_cnt", cnt0, 3);
      pop0 = 1'b1;
      for (int k = 0; k < 3; k++) begin
        cyc;
        chk("wrap_data", pd0, r * 3 + k);
        chk("wrap_valid", pv0, 1);
      end
      pop0 = 1'b0;
    end
    chk("wrap_empty", empty0, 1);

    // ---------------- simultaneous push+pop ----------------
    push0 = 1'b1; din0 = 8'h20; cyc;
    din0 = 8'h21; cyc;
    for (int i = 0; i < 10; i++) begin
      push0 = 1'b1; pop0 = 1'b1; din0 = 8'(8'h22 + i);
      cyc;
      chk("sim_cnt", cnt0, 2);
      chk("sim_data", pd0, 8'h20 + i);
    end
    push0 = 1'b0; pop0 = 1'b1;
    cyc; chk("sim_tail0", pd0, 8'h2A);
    cyc; chk("sim_tail1", pd0, 8'h2B);
    pop0 = 1'b0;
    cyc;
    chk("sim_empty", empty0, 1);

    push0 = 1'b1; pop0 = 1'b1; din0 = 8'hAA;
    cyc;
    chk("emp_pp_cnt", cnt0, 1);
    chk("emp_pp_udf", udf0, 1);
    chk("emp_pp_valid", pv0, 0);
    push0 = 1'b0; pop0 = 1'b1;
    cyc;
    pop0 = 1'b0;
    chk("emp_pp_data", pd0, 8'hAA);
    chk("emp_pp_valid2", pv0, 1);
    clr0 = 1'b1;
    cyc;
    clr0 = 1'b0;
    chk("udf_clr", udf0, 0);

    // ---------------- push+pop while full ----------------
    for (int i = 0; i < 5; i++) begin
      push0 = 1'b1; din0 = 8'(8'h30 + i);
      cyc;
    end
    push0 = 1'b1; pop0 = 1'b1; din0 = 8'h35;
    cyc;
    chk("full_pp_cnt", cnt0, 4);
    chk("full_pp_ovf", ovf0, 1);
    chk("full_pp_data", pd0, 8'h30);
    pop0 = 1'b0; din0 = 8'h36;
    cyc;
    push0 = 1'b0;
    chk("refill_full", full0, 1);

    // ---------------- error clear priority ----------------
    clr0 = 1'b1;
    cyc;
    chk("clr_alone", ovf0, 0);
    push0 = 1'b1; din0 = 8'h37;
    cyc;
    push0 = 1'b0; clr0 = 1'b0;
    chk("set_beats_clr", ovf0, 1);
    chk("set_beats_clr_cnt", cnt0, 5);

    // ---------------- async reset mid-stream ----------------
    pop0 = 1'b1;
    cyc; cyc;
    pop0 = 1'b0;
    chk("pre_rst_cnt", cnt0, 3);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_cnt", cnt0, 0);   chk("arst_empty", empty0, 1);
    chk("arst_ae", ae0, 1);     chk("arst_full", full0, 0);
    chk("arst_af", af0, 0);     chk("arst_ovf", ovf0, 0);
    chk("arst_udf", udf0, 0);   chk("arst_pv", pv0, 0);
    chk("arst_pd", pd0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    push0 = 1'b1; din0 = 8'h77;
    cyc;
    push0 = 1'b0; pop0 = 1'b1;
    cyc;
    pop0 = 1'b0;
    chk("post_rst_data", pd0, 8'h77);
    chk("post_rst_valid", pv0, 1);
    chk("post_rst_cnt", cnt0, 0);

    // ---------------- FWFT instance ----------------
    chk("fwft_idle_valid", pv1, 0);
    chk("fwft_idle_data", pd1, 0);
    push1 = 1'b1; din1 = 8'h5A;
    cyc;
    push1 = 1'b0;
    chk("fwft_valid", pv1, 1);
    chk("fwft_data", pd1, 8'h5A);
    cyc;
    chk("fwft_hold", pd1, 8'h5A);
    pop1 = 1'b1;
    cyc;
    pop1 = 1'b0;
    chk("fwft_empty", empty1, 1);
    chk("fwft_zero", pd1, 0);
    chk("fwft_novalid", pv1, 0);
    push1 = 1'b1; din1 = 8'h01; cyc;
    din1 = 8'h02; cyc;
    push1 = 1'b0;
    chk("fwft_head0", pd1, 8'h01);
    pop1 = 1'b1;
    cyc;
    pop1 = 1'b0;
    chk("fwft_head1", pd1, 8'h02);
    chk("fwft_cnt", cnt1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
